// File: rtl/flood_engine.sv
// flood_engine: owns the flooded-region bitmap of the flood-it game.
// Each accepted move grows the region from cell (0,0) into cells of the
// chosen colour, repaints the region in board RAM, then updates MOVES/WON.
// Optional build macro FLOOD_CELLCOUNT_EN adds the REGION_CELLS counter port.
module flood_engine #(
  parameter int MAX_SIZE = 26,
  parameter int COLOR_W  = 3
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               START_NEW_GAME,
  output logic               STARTED_GAME,
  input  logic [4:0]         SIZE,
  input  logic               COLOR_SEL_SIG,
  input  logic [COLOR_W-1:0] COLOR_SELECTED,
  output logic               CHANGING_COLOR,
  output logic [9:0]         CELL_ADDR,
  input  logic [COLOR_W-1:0] CELL_RD,
  output logic               CELL_WE,
  output logic [COLOR_W-1:0] CELL_WD,
  output logic [7:0]         MOVES,
`ifdef FLOOD_CELLCOUNT_EN
  output logic [9:0]         REGION_CELLS,
`endif
  output logic               WON
);

  localparam logic [4:0] MAX_SZ = 5'(MAX_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_GROW, S_WRITE, S_CHECK, S_NOP} state_t;

  state_t               state_r;
  logic [MAX_SIZE-1:0]  flag_r [MAX_SIZE];
  logic [4:0]           sz_r, row_r, col_r;
  logic [4:0]           p1_row_r, p1_col_r, p2_row_r, p2_col_r;
  logic                 p1_v_r, p2_v_r, issue_r, changed_r, init_mode_r, init_cnt_r;
  logic                 sig_low_seen_r, start_armed_r;
  logic [COLOR_W-1:0]   cur_color_r, target_r, cell_wd_r;
  logic                 started_r, changing_r, cell_we_r, won_r;
  logic [9:0]           cell_addr_r;
  logic [7:0]           moves_r;
`ifdef FLOOD_CELLCOUNT_EN
  logic [9:0]           region_cells_r;
`endif

  logic                 start_go_s, last_cell_s, p2_last_s, nbr_hit_s, grow_hit_s, all_set_s;
  logic [4:0]           n_row_s, s_row_s, w_col_s, e_col_s;

  function automatic logic [9:0] cell_addr(input logic [4:0] r, input logic [4:0] c);
    return 10'(r) * 10'(MAX_SIZE) + 10'(c);
  endfunction

  function automatic logic [4:0] clamp_size(input logic [4:0] s);
    logic [4:0] res;
    if (s < 5'd2)        res = 5'd2;
    else if (s > MAX_SZ) res = MAX_SZ;
    else                 res = s;
    return res;
  endfunction

  // A new game is taken once per START assertion so a held level cannot restart forever.
  assign start_go_s  = START_NEW_GAME & start_armed_r;
  assign last_cell_s = (row_r == sz_r - 5'd1) && (col_r == sz_r - 5'd1);
  assign p2_last_s   = (p2_row_r == sz_r - 5'd1) && (p2_col_r == sz_r - 5'd1);

  // Neighbour-hit of the cell whose read data is on CELL_RD (indices kept in range).
  always_comb begin
    n_row_s   = (p2_row_r != 5'd0) ? p2_row_r - 5'd1 : p2_row_r;
    s_row_s   = (p2_row_r + 5'd1 < sz_r) ? p2_row_r + 5'd1 : p2_row_r;
    w_col_s   = (p2_col_r != 5'd0) ? p2_col_r - 5'd1 : p2_col_r;
    e_col_s   = (p2_col_r + 5'd1 < sz_r) ? p2_col_r + 5'd1 : p2_col_r;
    nbr_hit_s = (flag_r[n_row_s][p2_col_r] & (p2_row_r != 5'd0))
              | (flag_r[s_row_s][p2_col_r] & (p2_row_r + 5'd1 < sz_r))
              | (flag_r[p2_row_r][w_col_s] & (p2_col_r != 5'd0))
              | (flag_r[p2_row_r][e_col_s] & (p2_col_r + 5'd1 < sz_r));
    grow_hit_s = p2_v_r & ~flag_r[p2_row_r][p2_col_r] & (CELL_RD == target_r) & nbr_hit_s;
  end

  // Win detect: every in-bounds flag set.
  always_comb begin
    all_set_s = 1'b1;
    for (int r = 0; r < MAX_SIZE; r++) begin
      for (int c = 0; c < MAX_SIZE; c++) begin
        all_set_s = all_set_s & (flag_r[r][c] | (5'(r) >= sz_r) | (5'(c) >= sz_r));
      end
    end
  end

  // Main controller: handshakes, scan counters, read pipeline, bitmap and outputs.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r        <= S_IDLE;
      for (int r = 0; r < MAX_SIZE; r++) flag_r[r] <= {MAX_SIZE{1'b0}};
      sz_r           <= 5'd2;
      row_r          <= 5'd0;
      col_r          <= 5'd0;
      p1_row_r       <= 5'd0;
      p1_col_r       <= 5'd0;
      p2_row_r       <= 5'd0;
      p2_col_r       <= 5'd0;
      p1_v_r         <= 1'b0;
      p2_v_r         <= 1'b0;
      issue_r        <= 1'b0;
      changed_r      <= 1'b0;
      init_mode_r    <= 1'b0;
      init_cnt_r     <= 1'b0;
      sig_low_seen_r <= 1'b0;
      start_armed_r  <= 1'b1;
      cur_color_r    <= {COLOR_W{1'b0}};
      target_r       <= {COLOR_W{1'b0}};
      cell_wd_r      <= {COLOR_W{1'b0}};
      started_r      <= 1'b0;
      changing_r     <= 1'b0;
      cell_we_r      <= 1'b0;
      won_r          <= 1'b0;
      cell_addr_r    <= 10'd0;
      moves_r        <= 8'd0;
`ifdef FLOOD_CELLCOUNT_EN
      region_cells_r <= 10'd0;
`endif
    end else begin
      started_r <= 1'b0;
      if (!COLOR_SEL_SIG) sig_low_seen_r <= 1'b1;
      if (!START_NEW_GAME) start_armed_r <= 1'b1;
      if (start_go_s) begin
        start_armed_r <= 1'b0;
        state_r       <= S_INIT;
        init_cnt_r    <= 1'b0;
        cell_we_r     <= 1'b0;
        cell_addr_r   <= 10'd0;
        changing_r    <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (COLOR_SEL_SIG && !won_r && sig_low_seen_r) begin
              changing_r     <= 1'b1;
              target_r       <= COLOR_SELECTED;
              sig_low_seen_r <= 1'b0;
              init_mode_r    <= 1'b0;
              if (COLOR_SELECTED == cur_color_r) begin
                state_r <= S_NOP;
              end else begin
                state_r   <= S_GROW;
                row_r     <= 5'd0;
                col_r     <= 5'd0;
                issue_r   <= 1'b1;
                p1_v_r    <= 1'b0;
                p2_v_r    <= 1'b0;
                changed_r <= 1'b0;
              end
            end
          end
          S_INIT: begin
            if (!init_cnt_r) begin
              // Address 0 is on the bus this cycle; its data arrives next cycle.
              for (int r = 0; r < MAX_SIZE; r++) flag_r[r] <= {MAX_SIZE{1'b0}};
              flag_r[0][0] <= 1'b1;
              sz_r         <= clamp_size(SIZE);
              init_cnt_r   <= 1'b1;
`ifdef FLOOD_CELLCOUNT_EN
              region_cells_r <= 10'd1;
`endif
            end else begin
              cur_color_r <= CELL_RD;
              target_r    <= CELL_RD;
              moves_r     <= 8'd0;
              won_r       <= 1'b0;
              init_mode_r <= 1'b1;
              state_r     <= S_GROW;
              row_r       <= 5'd0;
              col_r       <= 5'd0;
              issue_r     <= 1'b1;
              p1_v_r      <= 1'b0;
              p2_v_r      <= 1'b0;
              changed_r   <= 1'b0;
            end
          end
          S_GROW: begin
            // Stage 0 issues the address, stage p1 waits on RAM, stage p2 sees CELL_RD.
            p1_v_r <= issue_r;
            if (issue_r) begin
              cell_addr_r <= cell_addr(row_r, col_r);
              p1_row_r    <= row_r;
              p1_col_r    <= col_r;
              if (last_cell_s) begin
                issue_r <= 1'b0;
              end else if (col_r == sz_r - 5'd1) begin
                col_r <= 5'd0;
                row_r <= row_r + 5'd1;
              end else begin
                col_r <= col_r + 5'd1;
              end
            end
            p2_v_r   <= p1_v_r;
            p2_row_r <= p1_row_r;
            p2_col_r <= p1_col_r;
            if (grow_hit_s) begin
              flag_r[p2_row_r][p2_col_r] <= 1'b1;
              changed_r <= 1'b1;
`ifdef FLOOD_CELLCOUNT_EN
              region_cells_r <= region_cells_r + 10'd1;
`endif
            end
            if (p2_v_r && p2_last_s) begin
              if (changed_r || grow_hit_s) begin
                changed_r <= 1'b0;
                row_r     <= 5'd0;
                col_r     <= 5'd0;
                issue_r   <= 1'b1;
              end else if (init_mode_r) begin
                started_r <= 1'b1;
                state_r   <= S_IDLE;
              end else begin
                state_r <= S_WRITE;
                row_r   <= 5'd0;
                col_r   <= 5'd0;
              end
            end
          end
          S_WRITE: begin
            cell_we_r   <= flag_r[row_r][col_r];
            cell_addr_r <= cell_addr(row_r, col_r);
            cell_wd_r   <= target_r;
            if (last_cell_s) begin
              cur_color_r <= target_r;
              if (moves_r != 8'hFF) moves_r <= moves_r + 8'd1;
              state_r <= S_CHECK;
            end else if (col_r == sz_r - 5'd1) begin
              col_r <= 5'd0;
              row_r <= row_r + 5'd1;
            end else begin
              col_r <= col_r + 5'd1;
            end
          end
          S_CHECK: begin
            cell_we_r  <= 1'b0;
            won_r      <= all_set_s;
            changing_r <= 1'b0;
            state_r    <= S_IDLE;
          end
          S_NOP: begin
            changing_r <= 1'b0;
            state_r    <= S_IDLE;
          end
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

  assign STARTED_GAME   = started_r;
  assign CHANGING_COLOR = changing_r;
  assign CELL_ADDR      = cell_addr_r;
  assign CELL_WE        = cell_we_r;
  assign CELL_WD        = cell_wd_r;
  assign MOVES          = moves_r;
  assign WON            = won_r;
`ifdef FLOOD_CELLCOUNT_EN
  assign REGION_CELLS   = region_cells_r;
`endif

endmodule
